axi_lite_regfile: RTL and testbench

AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

---
 rtl/axi_lite_pkg.sv | 13 +
 rtl/axi_lite_if.sv | 31 +++
 rtl/axi_lite_regs.sv | 28 ++
 rtl/axi_lite_regfile.sv | 108 ++++++++++
 tb/tb_axi_lite_regfile.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared widths, types and response codes for the AXI4-Lite register file
package axi_lite_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [DATA_W/8-1:0] strb_t;
    typedef logic [1:0] resp_t;
    localparam resp_t RESP_OKAY = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;
endpackage

// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI4-Lite bus bundle including clock and active-low reset
interface axi_lite_if;
    import axi_lite_pkg::*;
    logic aclk;
    logic areset_n;
    addr_t awaddr;
    logic awvalid;
    logic awready;
    data_t wdata;
    strb_t wstrb;
    logic wvalid;
    logic wready;
    resp_t bresp;
    logic bvalid;
    logic bready;
    addr_t araddr;
    logic arvalid;
    logic arready;
    data_t rdata;
    resp_t rresp;
    logic rvalid;
    logic rready;
    modport slave (
        input aclk, areset_n, awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport master (
        input aclk, areset_n, awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready
    );
endinterface

// File: rtl/axi_lite_regs.sv
// axi_lite_regs: DEPTH x DATA_W storage, byte-enabled sync write, combinational read, sync clear
module axi_lite_regs
    import axi_lite_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  data_t                    wdata,
    input  strb_t                    wstrb,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output data_t                    rdata
);
    data_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            for (int b = 0; b < DATA_W / 8; b++)
                if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile: AXI4-Lite slave with independent read/write FSMs over a byte-strobed register file
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int    DEPTH     = 32,
    parameter addr_t BASE_ADDR = '0
) (
    axi_lite_if.slave s_axi_lite
);
    localparam int IW = $clog2(DEPTH);
    localparam int SH = $clog2(DATA_W / 8);
    localparam addr_t SPAN = addr_t'(DEPTH * (DATA_W / 8));

    function automatic logic hit(input addr_t a);
        return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
    endfunction

    function automatic logic [IW-1:0] idx(input addr_t a);
        return IW'((a - BASE_ADDR) >> SH);
    endfunction

    wstate_t wstate, wstate_nx;
    rstate_t rstate, rstate_nx;
    logic    aw_held, w_held;
    addr_t   aw_addr_q;
    data_t   w_data_q, rdata_q, mem_rdata;
    strb_t   w_strb_q;
    resp_t   bresp_q, rresp_q;

    wire   rst = !s_axi_lite.areset_n;
    wire   aw_hs = wstate == W_IDLE && !aw_held && s_axi_lite.awvalid;
    wire   w_hs = wstate == W_IDLE && !w_held && s_axi_lite.wvalid;
    wire   commit = (aw_held || aw_hs) && (w_held || w_hs);
    wire   ar_hs = rstate == R_IDLE && s_axi_lite.arvalid;
    addr_t cur_addr;
    data_t cur_data;
    strb_t cur_strb;

    assign cur_addr = aw_held ? aw_addr_q : s_axi_lite.awaddr;
    assign cur_data = w_held ? w_data_q : s_axi_lite.wdata;
    assign cur_strb = w_held ? w_strb_q : s_axi_lite.wstrb;

    axi_lite_regs #(.DEPTH(DEPTH)) u_regs (
        .clk   (s_axi_lite.aclk),
        .clr   (rst),
        .we    (commit && hit(cur_addr)),
        .waddr (idx(cur_addr)),
        .wdata (cur_data),
        .wstrb (cur_strb),
        .raddr (idx(s_axi_lite.araddr)),
        .rdata (mem_rdata)
    );

    always_comb begin
        wstate_nx = commit ? W_RESP : (wstate == W_RESP && s_axi_lite.bready) ? W_IDLE : wstate;
        rstate_nx = ar_hs ? R_DATA : (rstate == R_DATA && s_axi_lite.rready) ? R_IDLE : rstate;
    end

    always_ff @(posedge s_axi_lite.aclk) begin
        wstate <= rst ? W_IDLE : wstate_nx;
        rstate <= rst ? R_IDLE : rstate_nx;
    end

    always_ff @(posedge s_axi_lite.aclk) begin
        if (rst) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bresp_q <= hit(cur_addr) ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= s_axi_lite.awaddr;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= s_axi_lite.wdata;
                w_strb_q <= s_axi_lite.wstrb;
            end
        end
    end

    // Storage updates on this same edge, so a colliding read captures the pre-write value.
    always_ff @(posedge s_axi_lite.aclk) begin
        if (rst) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= hit(s_axi_lite.araddr) ? mem_rdata : '0;
            rresp_q <= hit(s_axi_lite.araddr) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign s_axi_lite.awready = wstate == W_IDLE && !aw_held;
    assign s_axi_lite.wready  = wstate == W_IDLE && !w_held;
    assign s_axi_lite.bvalid  = wstate == W_RESP;
    assign s_axi_lite.bresp   = bresp_q;
    assign s_axi_lite.arready = rstate == R_IDLE;
    assign s_axi_lite.rvalid  = rstate == R_DATA;
    assign s_axi_lite.rdata   = rdata_q;
    assign s_axi_lite.rresp   = rresp_q;
endmodule

// File: tb/tb_axi_lite_regfile.sv
// tb_axi_lite_regfile: directed self-checking bench for axi_lite_regfile
module tb_axi_lite_regfile;
    import axi_lite_pkg::*;

    logic clk = 1'b0;
    int checks = 0;
    int errors = 0;

    axi_lite_if bus ();
    axi_lite_regfile #(.DEPTH(32), .BASE_ADDR(32'h0)) dut (.s_axi_lite(bus));

    assign bus.aclk = clk;
    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_write(input addr_t a, input data_t d, input strb_t s, output resp_t r, output bit ok);
        int n = 0;
        logic aw_go, w_go;
        bus.awaddr = a;
        bus.awvalid = 1'b1;
        bus.wdata = d;
        bus.wstrb = s;
        bus.wvalid = 1'b1;
        bus.bready = 1'b1;
        while ((bus.awvalid || bus.wvalid) && n < 20) begin
            aw_go = bus.awvalid && bus.awready;
            w_go = bus.wvalid && bus.wready;
            cycles(1);
            if (aw_go) bus.awvalid = 1'b0;
            if (w_go) bus.wvalid = 1'b0;
            n++;
        end
        while (!bus.bvalid && n < 20) begin
            cycles(1);
            n++;
        end
        ok = bus.bvalid;
        r = bus.bresp;
        cycles(1);
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b0;
        bus.bready = 1'b0;
    endtask

    task automatic do_read(input addr_t a, output data_t d, output resp_t r, output bit ok);
        int n = 0;
        bus.araddr = a;
        bus.arvalid = 1'b1;
        bus.rready = 1'b1;
        while (!bus.arready && n < 20) begin
            cycles(1);
            n++;
        end
        cycles(1);
        bus.arvalid = 1'b0;
        while (!bus.rvalid && n < 20) begin
            cycles(1);
            n++;
        end
        ok = bus.rvalid;
        d = bus.rdata;
        r = bus.rresp;
        cycles(1);
        bus.rready = 1'b0;
    endtask

    task automatic test_reset();
        bus.areset_n = 1'b0;
        cycles(2);
        checks++;
        if ({bus.arready, bus.awready, bus.wready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready got ar/aw/w=%b%b%b want 111", bus.arready, bus.awready, bus.wready);
        end
        checks++;
        if ({bus.rvalid, bus.bvalid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_valid got r/b=%b%b want 00", bus.rvalid, bus.bvalid);
        end
        checks++;
        if (bus.rdata !== 32'h0 || bus.rresp !== RESP_OKAY || bus.bresp !== RESP_OKAY) begin
            errors++;
            $display("FAIL reset_data got rdata=%h rresp=%b bresp=%b want 0 00 00", bus.rdata, bus.rresp, bus.bresp);
        end
        bus.areset_n = 1'b1;
        cycles(1);
    endtask

    task automatic test_out_of_range();
        data_t d;
        resp_t r;
        bit ok;
        do_read(32'h80, d, r, ok);
        checks++;
        if (!ok || d !== 32'h0 || r !== RESP_SLVERR) begin
            errors++;
            $display("FAIL oor_read got ok=%0b data=%h resp=%b want 1 0 10", ok, d, r);
        end
        do_write(32'h80, 32'hFFFF_FFFF, 4'hF, r, ok);
        checks++;
        if (!ok || r !== RESP_SLVERR) begin
            errors++;
            $display("FAIL oor_write got ok=%0b resp=%b want 1 10", ok, r);
        end
        do_read(32'hFFFF_FFFC, d, r, ok);
        checks++;
        if (!ok || d !== 32'h0 || r !== RESP_SLVERR) begin
            errors++;
            $display("FAIL oor_far got ok=%0b data=%h resp=%b want 1 0 10", ok, d, r);
        end
        for (int i = 0; i < 32; i++) begin
            do_read(addr_t'(i * 4), d, r, ok);
            checks++;
            if (!ok || d !== 32'h0 || r !== RESP_OKAY) begin
                errors++;
                $display("FAIL oor_clean[%0d] got ok=%0b data=%h resp=%b want 1 0 00", i, ok, d, r);
            end
        end
    endtask

    task automatic test_basic();
        data_t d;
        resp_t r;
        bit ok;
        do_write(32'h10, 32'hDEAD_BEEF, 4'hF, r, ok);
        checks++;
        if (!ok || r !== RESP_OKAY) begin
            errors++;
            $display("FAIL basic_bresp got ok=%0b resp=%b want 1 00", ok, r);
        end
        do_read(32'h10, d, r, ok);
        checks++;
        if (!ok || d !== 32'hDEAD_BEEF || r !== RESP_OKAY) begin
            errors++;
            $display("FAIL basic_read got ok=%0b data=%h resp=%b want 1 deadbeef 00", ok, d, r);
        end
    endtask

    task automatic test_w_before_aw();
        data_t d;
        resp_t r;
        bit ok;
        bus.wdata = 32'h1122_3344;
        bus.wstrb = 4'h5;
        bus.wvalid = 1'b1;
        bus.bready = 1'b0;
        cycles(1);
        bus.wvalid = 1'b0;
        checks++;
        if (bus.wready !== 1'b0 || bus.awready !== 1'b1) begin
            errors++;
            $display("FAIL wfirst_ready got wready=%b awready=%b want 0 1", bus.wready, bus.awready);
        end
        cycles(2);
        checks++;
        if (bus.bvalid !== 1'b0) begin
            errors++;
            $display("FAIL wfirst_early_b got bvalid=%b want 0", bus.bvalid);
        end
        bus.awaddr = 32'h4;
        bus.awvalid = 1'b1;
        cycles(1);
        bus.awvalid = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b1 || bus.bresp !== RESP_OKAY) begin
            errors++;
            $display("FAIL wfirst_b got bvalid=%b bresp=%b want 1 00", bus.bvalid, bus.bresp);
        end
        bus.bready = 1'b1;
        cycles(1);
        bus.bready = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b0) begin
            errors++;
            $display("FAIL wfirst_b_done got bvalid=%b want 0", bus.bvalid);
        end
        do_read(32'h4, d, r, ok);
        checks++;
        if (!ok || d !== 32'h0022_0044 || r !== RESP_OKAY) begin
            errors++;
            $display("FAIL wfirst_read got ok=%0b data=%h resp=%b want 1 00220044 00", ok, d, r);
        end
        do_read(32'h7, d, r, ok);
        checks++;
        if (!ok || d !== 32'h0022_0044 || r !== RESP_OKAY) begin
            errors++;
            $display("FAIL unaligned_read got ok=%0b data=%h resp=%b want 1 00220044 00", ok, d, r);
        end
    endtask

    task automatic test_strobes();
        data_t d;
        resp_t r;
        bit ok;
        do_write(32'h10, 32'h0, 4'h0, r, ok);
        checks++;
        if (!ok || r !== RESP_OKAY) begin
            errors++;
            $display("FAIL strb0_bresp got ok=%0b resp=%b want 1 00", ok, r);
        end
        do_read(32'h10, d, r, ok);
        checks++;
        if (!ok || d !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL strb0_read got ok=%0b data=%h want 1 deadbeef", ok, d);
        end
        do_write(32'h10, 32'h0000_0077, 4'h1, r, ok);
        do_read(32'h10, d, r, ok);
        checks++;
        if (!ok || d !== 32'hDEAD_BE77) begin
            errors++;
            $display("FAIL strb1_read got ok=%0b data=%h want 1 deadbe77", ok, d);
        end
    endtask

    task automatic test_same_edge();
        data_t d;
        resp_t r;
        bit ok;
        bus.awaddr = 32'h8;
        bus.awvalid = 1'b1;
        bus.wdata = 32'hA5A5_A5A5;
        bus.wstrb = 4'hF;
        bus.wvalid = 1'b1;
        bus.araddr = 32'h8;
        bus.arvalid = 1'b1;
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        cycles(1);
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b0;
        bus.arvalid = 1'b0;
        checks++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0 || bus.rresp !== RESP_OKAY) begin
            errors++;
            $display("FAIL same_edge_read got rvalid=%b data=%h resp=%b want 1 0 00", bus.rvalid, bus.rdata, bus.rresp);
        end
        checks++;
        if (bus.bvalid !== 1'b1 || bus.bresp !== RESP_OKAY) begin
            errors++;
            $display("FAIL same_edge_b got bvalid=%b bresp=%b want 1 00", bus.bvalid, bus.bresp);
        end
        cycles(1);
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        do_read(32'h8, d, r, ok);
        checks++;
        if (!ok || d !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL same_edge_after got ok=%0b data=%h want 1 a5a5a5a5", ok, d);
        end
    endtask

    task automatic test_backpressure();
        data_t d;
        resp_t r;
        bit ok;
        bus.awaddr = 32'h14;
        bus.awvalid = 1'b1;
        bus.wdata = 32'h0102_0304;
        bus.wstrb = 4'hF;
        bus.wvalid = 1'b1;
        bus.araddr = 32'h10;
        bus.arvalid = 1'b1;
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        cycles(1);
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b0;
        bus.arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.bvalid !== 1'b1 || bus.bresp !== RESP_OKAY) begin
                errors++;
                $display("FAIL bp_b[%0d] got bvalid=%b bresp=%b want 1 00", i, bus.bvalid, bus.bresp);
            end
            checks++;
            if (bus.awready !== 1'b0 || bus.wready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready[%0d] got awready=%b wready=%b want 0 0", i, bus.awready, bus.wready);
            end
            checks++;
            if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hDEAD_BE77 || bus.rresp !== RESP_OKAY) begin
                errors++;
                $display("FAIL bp_r[%0d] got rvalid=%b data=%h resp=%b want 1 deadbe77 00", i, bus.rvalid, bus.rdata, bus.rresp);
            end
            cycles(1);
        end
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        cycles(1);
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got bvalid=%b rvalid=%b want 0 0", bus.bvalid, bus.rvalid);
        end
        do_read(32'h14, d, r, ok);
        checks++;
        if (!ok || d !== 32'h0102_0304) begin
            errors++;
            $display("FAIL bp_read got ok=%0b data=%h want 1 01020304", ok, d);
        end
    endtask

    task automatic test_reset_mid();
        data_t d;
        resp_t r;
        bit ok;
        bus.awaddr = 32'hC;
        bus.awvalid = 1'b1;
        cycles(1);
        bus.awvalid = 1'b0;
        bus.areset_n = 1'b0;
        cycles(1);
        bus.areset_n = 1'b1;
        bus.wdata = 32'h5555_5555;
        bus.wstrb = 4'hF;
        bus.wvalid = 1'b1;
        bus.bready = 1'b1;
        cycles(1);
        bus.wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.bvalid !== 1'b0) begin
                errors++;
                $display("FAIL rmid_stray_b[%0d] got bvalid=%b want 0", i, bus.bvalid);
            end
            cycles(1);
        end
        checks++;
        if (bus.wready !== 1'b0 || bus.awready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_ready got wready=%b awready=%b want 0 1", bus.wready, bus.awready);
        end
        bus.bready = 1'b0;
        bus.awaddr = 32'h80;
        bus.awvalid = 1'b1;
        cycles(1);
        bus.awvalid = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b1 || bus.bresp !== RESP_SLVERR) begin
            errors++;
            $display("FAIL rmid_b got bvalid=%b bresp=%b want 1 10", bus.bvalid, bus.bresp);
        end
        bus.bready = 1'b1;
        cycles(1);
        bus.bready = 1'b0;
        do_read(32'hC, d, r, ok);
        checks++;
        if (!ok || d !== 32'h0) begin
            errors++;
            $display("FAIL rmid_reg3 got ok=%0b data=%h want 1 0", ok, d);
        end
        do_read(32'h10, d, r, ok);
        checks++;
        if (!ok || d !== 32'h0) begin
            errors++;
            $display("FAIL rmid_cleared got ok=%0b data=%h want 1 0", ok, d);
        end
    endtask

    initial begin
        bus.areset_n = 1'b0;
        bus.awaddr = '0;
        bus.awvalid = 1'b0;
        bus.wdata = '0;
        bus.wstrb = '0;
        bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.araddr = '0;
        bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        @(negedge clk);
        test_reset();
        test_out_of_range();
        test_basic();
        test_w_before_aw();
        test_strobes();
        test_same_edge();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
